// File: rtl/pattern_tx_if.sv
// Handshake and serial-output bundle between sequence control and pattern_tx.
interface pattern_tx_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             bit_en;
    logic             o;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt, bit_en,
        input  o, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt, bit_en,
        output o, busy, done
    );
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeat_cnt times, one bit per bit_en.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit after every repetition.
module pattern_tx #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input logic         clk,
    input logic         n_rst,
    pattern_tx_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(PAT_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef PATTERN_TX_PARITY_EN
        PARITY = 2'd2,
`endif
        SHIFT  = 2'd1
    } state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic [PAT_W-1:0] shreg, shreg_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             o, o_n;
    logic             busy, busy_n;
    logic             done, done_n;

    // State and datapath registers; outputs are registered alongside the state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            pat   <= '0;
            shreg <= '0;
            idx   <= '0;
            rcnt  <= '0;
            o     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            pat   <= pat_n;
            shreg <= shreg_n;
            idx   <= idx_n;
            rcnt  <= rcnt_n;
            o     <= o_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        pat_n   = pat;
        shreg_n = shreg;
        idx_n   = idx;
        rcnt_n  = rcnt;
        o_n     = o;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                o_n    = 1'b0;
                busy_n = 1'b0;
                if (bus.start) begin
                    if (bus.repeat_cnt != '0) begin
                        pat_n   = bus.pattern;
                        shreg_n = bus.pattern;
                        idx_n   = '0;
                        rcnt_n  = bus.repeat_cnt;
                        state_n = SHIFT;
                        o_n     = bus.pattern[PAT_W-1];
                        busy_n  = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            SHIFT: begin
                busy_n = 1'b1;
                if (bus.bit_en) begin
                    if (idx != IDX_W'(PAT_W - 1)) begin
                        shreg_n = shreg << 1;
                        idx_n   = idx + IDX_W'(1);
                        o_n     = shreg[PAT_W-2];
                    end else begin
`ifdef PATTERN_TX_PARITY_EN
                        state_n = PARITY;
                        o_n     = ^pat;
`else
                        rcnt_n = rcnt - CNT_W'(1);
                        if (rcnt != CNT_W'(1)) begin
                            shreg_n = pat;
                            idx_n   = '0;
                            o_n     = pat[PAT_W-1];
                        end else begin
                            state_n = IDLE;
                            o_n     = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
`endif
                    end
                end
            end

`ifdef PATTERN_TX_PARITY_EN
            PARITY: begin
                busy_n = 1'b1;
                if (bus.bit_en) begin
                    rcnt_n = rcnt - CNT_W'(1);
                    if (rcnt != CNT_W'(1)) begin
                        shreg_n = pat;
                        idx_n   = '0;
                        state_n = SHIFT;
                        o_n     = pat[PAT_W-1];
                    end else begin
                        state_n = IDLE;
                        o_n     = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_n = IDLE;
                o_n     = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.o    = o;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: randomized strobes against an expected-bit-stream model.
module tb_pattern_tx;
    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;

    pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one request and follows it bit by bit; the expected stream is the
    // pattern MSB-first repeated n times (plus parity per repetition when enabled).
    // mode: 0 = bit_en tied high, 1 = every third cycle, 2 = random.
    task automatic run_tx(input logic [3:0] p, input logic [3:0] n, input int mode,
                          input bit noise, input bit idle_after);
        logic exp_q[$];
        int   pos;
        int   cyc;
        bit   fin;
        logic en;
        logic [2:0] got;
        logic [2:0] want;
        pos = 0;
        cyc = 0;
        fin = 1'b0;
        for (int r = 0; r < int'(n); r++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back(p[b]);
`ifdef PATTERN_TX_PARITY_EN
            exp_q.push_back(^p);
`endif
        end

        @(negedge clk);
        bus.start      = 1'b1;
        bus.pattern    = p;
        bus.repeat_cnt = n;
        bus.bit_en     = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
        @(posedge clk);
        #1;
        got = {bus.busy, bus.o, bus.done};
        if (n == 4'd0) begin
            want = 3'b001;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL zero_cnt p=%b {busy,o,done} got=%b exp=%b", p, got, want);
            end
        end else begin
            want = {1'b1, exp_q[0], 1'b0};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL start_latency p=%b n=%0d {busy,o,done} got=%b exp=%b", p, n, got, want);
            end
            while (!fin) begin
                @(negedge clk);
                cyc++;
                bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                if (noise) begin
                    bus.pattern    = 4'b0110;
                    bus.repeat_cnt = 4'($urandom);
                end
                case (mode)
                    0:       bus.bit_en = 1'b1;
                    1:       bus.bit_en = (cyc % 3 == 0);
                    default: bus.bit_en = 1'($urandom_range(0, 1));
                endcase
                @(posedge clk);
                en = bus.bit_en;
                #1;
                if (en) pos++;
                got = {bus.busy, bus.o, bus.done};
                if (pos == exp_q.size()) begin
                    want = 3'b001;
                    fin  = 1'b1;
                end else begin
                    want = {1'b1, exp_q[pos], 1'b0};
                end
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL stream p=%b n=%0d bit=%0d {busy,o,done} got=%b exp=%b",
                             p, n, pos, got, want);
                end
                if (!fin && cyc > 500) begin
                    failures++;
                    $display("FAIL timeout p=%b n=%0d bit=%0d busy got=%b exp=0", p, n, pos, bus.busy);
                    fin = 1'b1;
                end
            end
        end

        if (idle_after) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.bit_en = 1'b1;
            @(posedge clk);
            #1;
            got = {bus.busy, bus.o, bus.done};
            checks++;
            if (got !== 3'b000) begin
                failures++;
                $display("FAIL done_drop p=%b n=%0d {busy,o,done} got=%b exp=000", p, n, got);
            end
        end
    endtask

    task automatic test_reset();
        logic [2:0] got;
        bus.start      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        bus.bit_en     = 1'b0;
        n_rst          = 1'b0;
        #12;
        got = {bus.busy, bus.o, bus.done};
        checks++;
        if (got !== 3'b000) begin
            failures++;
            $display("FAIL reset_state {busy,o,done} got=%b exp=000", got);
        end
        @(negedge clk);
        n_rst = 1'b1;

        // Start 1101, let two bits go out, then reset asynchronously mid-cycle.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.pattern    = 4'b1101;
        bus.repeat_cnt = 4'd1;
        bus.bit_en     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        got = {bus.busy, bus.o, bus.done};
        checks++;
        if (got !== 3'b110) begin
            failures++;
            $display("FAIL pre_reset_bit2 {busy,o,done} got=%b exp=110", got);
        end
        #2;
        n_rst = 1'b0;
        #1;
        got = {bus.busy, bus.o, bus.done};
        checks++;
        if (got !== 3'b000) begin
            failures++;
            $display("FAIL async_reset {busy,o,done} got=%b exp=000", got);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = {bus.busy, bus.o, bus.done};
            checks++;
            if (got !== 3'b000) begin
                failures++;
                $display("FAIL post_reset_idle cyc=%0d {busy,o,done} got=%b exp=000", i, got);
            end
        end
    endtask

    task automatic test_single();
        run_tx(4'b1101, 4'd1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_slow_repeat();
        run_tx(4'b1101, 4'd2, 1, 1'b0, 1'b1);
    endtask

    task automatic test_zero_and_ignored();
        run_tx(4'b1011, 4'd0, 0, 1'b0, 1'b1);
        run_tx(4'b1101, 4'd1, 2, 1'b1, 1'b1);
        run_tx(4'b1101, 4'd2, 0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_tx(4'b1011, 4'd1, 0, 1'b0, 1'b0);
        run_tx(4'b1101, 4'd2, 0, 1'b0, 1'b0);
        run_tx(4'b0111, 4'd1, 2, 1'b0, 1'b1);
    endtask

    task automatic test_parity_cases();
        run_tx(4'b1001, 4'd1, 0, 1'b0, 1'b1);
        run_tx(4'b1111, 4'd3, 0, 1'b0, 1'b1);
        run_tx(4'b0001, 4'd1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_tx(4'($urandom), 4'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_slow_repeat();
        test_zero_and_ignored();
        test_back_to_back();
        test_parity_cases();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
